// File: rtl/gost89_cfb_stream_ctrl_pkg.sv
// Shared encodings and GOST 28147-89 round helpers
// for the CFB stream controller and its cores.
package gost89_cfb_stream_ctrl_pkg;

  localparam int BLK_W = 64;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LDIV  = 3'd1;
  localparam logic [2:0] ST_WIN   = 3'd2;
  localparam logic [2:0] ST_LOAD  = 3'd3;
  localparam logic [2:0] ST_RUN   = 3'd4;
  localparam logic [2:0] ST_DRAIN = 3'd5;

  // Rounds 0..23 walk K0..K7 forward, 24..31 walk K7..K0.
  function automatic logic [2:0] key_idx(
    input logic [4:0] rnd
  );
    return (rnd[4:3] == 2'b11) ? ~rnd[2:0] : rnd[2:0];
  endfunction

  // Box j substitutes nibble j; entry v of box j is at bit (j*16+v)*4.
  function automatic logic [31:0] gost_f(
    input logic [31:0]  a,
    input logic [31:0]  k,
    input logic [511:0] sbox
  );
    logic [31:0] t;
    logic [31:0] s;
    t = a + k;
    s = '0;
    for (int j = 0; j < 8; j++) begin
      s[4*j +: 4] = sbox[{j[2:0], t[4*j +: 4], 2'b00} +: 4];
    end
    return {s[20:0], s[31:21]};
  endfunction

endpackage

// File: rtl/gost89_cfb_stream_ctrl_cores.sv
// GOST 28147-89 CFB encrypt/decrypt cores, one round
// per cycle, 32 cycles per block.
module gost89_cfb_encrypt
  import gost89_cfb_stream_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             core_reset,
  input  logic             core_load,
  input  logic [BLK_W-1:0] core_in,
  input  logic [511:0]     sbox,
  input  logic [255:0]     key,
  output logic [BLK_W-1:0] out,
  output logic             busy
);

  logic [BLK_W-1:0] gamma;
  logic [BLK_W-1:0] din;
  logic [31:0]      n1;
  logic [31:0]      n2;
  logic [4:0]       rnd;
  logic [31:0]      k;
  logic [31:0]      n1_nx;
  logic [BLK_W-1:0] res;

  assign k     = key[{key_idx(rnd), 5'd0} +: 32];
  assign n1_nx = n2 ^ gost_f(n1, k, sbox);
  assign res   = {n1_nx, n1} ^ din;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gamma <= '0;
      din   <= '0;
      n1    <= '0;
      n2    <= '0;
      rnd   <= '0;
      out   <= '0;
      busy  <= 1'b0;
    end else if (core_load) begin
      din  <= core_in;
      n1   <= gamma[31:0];
      n2   <= gamma[63:32];
      rnd  <= '0;
      busy <= 1'b1;
    end else if (core_reset) begin
      gamma <= core_in;
      busy  <= 1'b0;
    end else if (busy) begin
      n1  <= n1_nx;
      n2  <= n1;
      rnd <= rnd + 5'd1;
      if (rnd == 5'd31) begin
        busy  <= 1'b0;
        out   <= res;
        gamma <= res;
      end
    end
  end

endmodule

module gost89_cfb_decrypt
  import gost89_cfb_stream_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             core_reset,
  input  logic             core_load,
  input  logic [BLK_W-1:0] core_in,
  input  logic [511:0]     sbox,
  input  logic [255:0]     key,
  output logic [BLK_W-1:0] out,
  output logic             busy
);

  logic [BLK_W-1:0] gamma;
  logic [BLK_W-1:0] din;
  logic [31:0]      n1;
  logic [31:0]      n2;
  logic [4:0]       rnd;
  logic [31:0]      k;
  logic [31:0]      n1_nx;
  logic [BLK_W-1:0] res;

  assign k     = key[{key_idx(rnd), 5'd0} +: 32];
  assign n1_nx = n2 ^ gost_f(n1, k, sbox);
  assign res   = {n1_nx, n1} ^ din;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gamma <= '0;
      din   <= '0;
      n1    <= '0;
      n2    <= '0;
      rnd   <= '0;
      out   <= '0;
      busy  <= 1'b0;
    end else if (core_load) begin
      din  <= core_in;
      n1   <= gamma[31:0];
      n2   <= gamma[63:32];
      rnd  <= '0;
      busy <= 1'b1;
    end else if (core_reset) begin
      gamma <= core_in;
      busy  <= 1'b0;
    end else if (busy) begin
      n1  <= n1_nx;
      n2  <= n1;
      rnd <= rnd + 5'd1;
      if (rnd == 5'd31) begin
        busy  <= 1'b0;
        out   <= res;
        // decrypt feeds the ciphertext back, not the result
        gamma <= din;
      end
    end
  end

endmodule

// File: rtl/gost89_cfb_stream_ctrl.sv
// Session sequencer for the GOST 28147-89 CFB cores with a
// one-entry output buffer on the result stream.
module gost89_cfb_stream_ctrl
  import gost89_cfb_stream_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode,
  input  logic [BLK_W-1:0] iv,
  input  logic             abort,
  input  logic [511:0]     sbox,
  input  logic [255:0]     key,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [BLK_W-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [BLK_W-1:0] m_data,
  output logic             m_last,
  output logic             sess_busy,
  output logic             sess_done,
  output logic [CNT_W-1:0] blk_count
);

  logic [2:0]       state;
  logic             mode_q;
  logic             last_q;
  logic [BLK_W-1:0] core_in;
  logic             core_reset;
  logic             core_load;
  logic [BLK_W-1:0] enc_out;
  logic [BLK_W-1:0] dec_out;
  logic             enc_busy;
  logic             dec_busy;
  logic [BLK_W-1:0] core_out;
  logic             core_busy;
  logic             drain;
  logic             capture;

  assign core_reset = (state == ST_IDLE) || (state == ST_LDIV);
  assign core_load  = (state == ST_LOAD);
  assign core_out   = (mode_q == MODE_DEC) ? dec_out : enc_out;
  assign core_busy  = (mode_q == MODE_DEC) ? dec_busy : enc_busy;
  assign s_ready    = (state == ST_WIN);
  assign drain      = m_valid & m_ready;
  // a draining buffer can take the new result in the same cycle
  assign capture    = (state == ST_RUN) && !core_busy
                      && (!m_valid || m_ready);

  gost89_cfb_encrypt u_enc (
    .clk        (clk),
    .reset_n    (reset_n),
    .core_reset (core_reset | (mode_q != MODE_ENC)),
    .core_load  (core_load & (mode_q == MODE_ENC)),
    .core_in    (core_in),
    .sbox       (sbox),
    .key        (key),
    .out        (enc_out),
    .busy       (enc_busy)
  );

  gost89_cfb_decrypt u_dec (
    .clk        (clk),
    .reset_n    (reset_n),
    .core_reset (core_reset | (mode_q != MODE_DEC)),
    .core_load  (core_load & (mode_q == MODE_DEC)),
    .core_in    (core_in),
    .sbox       (sbox),
    .key        (key),
    .out        (dec_out),
    .busy       (dec_busy)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_ENC;
      last_q    <= 1'b0;
      core_in   <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      sess_busy <= 1'b0;
      sess_done <= 1'b0;
      blk_count <= '0;
    end else if (abort) begin
      state     <= ST_IDLE;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      sess_busy <= 1'b0;
      sess_done <= 1'b0;
    end else begin
      sess_done <= 1'b0;
      if (drain) begin
        m_valid   <= 1'b0;
        blk_count <= blk_count + 1'b1;
      end
      if (capture) begin
        m_valid <= 1'b1;
        m_data  <= core_out;
        m_last  <= last_q;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q    <= mode;
            core_in   <= iv;
            sess_busy <= 1'b1;
            blk_count <= '0;
            state     <= ST_LDIV;
          end
        end
        ST_LDIV: state <= ST_WIN;
        ST_WIN: begin
          if (s_valid) begin
            last_q  <= s_last;
            core_in <= s_data;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: state <= ST_RUN;
        ST_RUN: begin
          if (capture) begin
            state <= last_q ? ST_DRAIN : ST_WIN;
          end
        end
        ST_DRAIN: begin
          if (drain && m_last) begin
            sess_done <= 1'b1;
            sess_busy <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gost89_cfb_stream_ctrl.sv
// Randomized bench for gost89_cfb_stream_ctrl against a
// behavioural GOST 28147-89 CFB reference model.
module tb_gost89_cfb_stream_ctrl;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [63:0]  iv = '0;
  logic         abort = 1'b0;
  logic [511:0] sbox;
  logic [255:0] key;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [63:0]  s_data = '0;
  logic         s_last = 1'b0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [63:0]  m_data;
  logic         m_last;
  logic         sess_busy;
  logic         sess_done;
  logic [31:0]  blk_count;

  logic         s_ready2;
  logic         m_valid2;
  logic [63:0]  m_data2;
  logic         m_last2;
  logic         sess_busy2;
  logic         sess_done2;
  logic [1:0]   blk_count2;

  int n_checks = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int acc_cnt = 0;

  logic [63:0] q_in[$];
  logic [63:0] q_exp[$];
  logic [63:0] q_out[$];
  bit          q_last[$];
  logic [31:0] kw [8];

  // CryptoPro-A parameter set, box j applies to nibble j
  int sbt [8][16] = '{
    '{9,6,3,2,8,11,1,7,10,4,14,15,12,0,13,5},
    '{3,7,14,9,8,10,15,0,5,2,6,12,11,4,13,1},
    '{14,4,6,2,11,3,13,8,12,15,5,10,0,7,1,9},
    '{14,7,10,12,13,1,3,9,0,2,11,4,15,8,5,6},
    '{11,5,1,9,8,13,15,0,14,4,2,3,12,7,10,6},
    '{3,10,13,12,1,2,0,11,7,5,9,4,8,15,14,6},
    '{1,13,2,9,7,10,6,0,8,12,4,5,15,3,11,14},
    '{11,10,15,5,0,12,14,8,6,2,3,9,1,7,13,4}
  };

  gost89_cfb_stream_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .iv(iv), .abort(abort), .sbox(sbox), .key(key),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .sess_busy(sess_busy),
    .sess_done(sess_done), .blk_count(blk_count)
  );

  gost89_cfb_stream_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .iv(iv), .abort(abort), .sbox(sbox), .key(key),
    .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid2), .m_ready(m_ready),
    .m_data(m_data2), .m_last(m_last2), .sess_busy(sess_busy2),
    .sess_done(sess_done2), .blk_count(blk_count2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sess_done) done_cnt <= done_cnt + 1;
    if (s_valid && s_ready) acc_cnt <= acc_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] gost_e(input logic [63:0] blk);
    logic [31:0] a, b, t, s, tmp;
    int ki, nib;
    a = blk[31:0];
    b = blk[63:32];
    for (int r = 0; r < 32; r++) begin
      ki = (r < 24) ? (r % 8) : (7 - (r % 8));
      t = a + kw[ki];
      s = '0;
      for (int j = 0; j < 8; j++) begin
        nib = int'((t >> (4 * j)) & 32'hf);
        s = s | (32'(sbt[j][nib]) << (4 * j));
      end
      s = (s << 11) | (s >> 21);
      tmp = b ^ s;
      b = a;
      a = tmp;
    end
    return {a, b};
  endfunction

  // CFB over the queued blocks: out = in ^ E(gamma), gamma <- ciphertext
  task automatic model(input bit dec, input logic [63:0] ivv);
    logic [63:0] g, o;
    q_exp.delete();
    g = ivv;
    foreach (q_in[i]) begin
      o = q_in[i] ^ gost_e(g);
      q_exp.push_back(o);
      g = dec ? q_in[i] : o;
    end
  endtask

  task automatic start_pulse(input bit md, input logic [63:0] ivv);
    @(negedge clk);
    start = 1'b1;
    mode = md;
    iv = ivv;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int n, input bit mark_last);
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      s_valid = 1'b1;
      s_data = q_in[i];
      s_last = mark_last && (i == n - 1);
      while (!s_ready && t < 4000) begin
        @(negedge clk);
        t++;
      end
      if (!s_ready) begin
        n_checks++;
        $display("FAIL feed_timeout blk%0d s_ready never rose", i);
        break;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic consume(input int pct);
    int t;
    bit done;
    t = 0;
    done = 0;
    q_out.delete();
    q_last.delete();
    while (!done && t < 8000) begin
      @(negedge clk);
      t++;
      m_ready = ($urandom_range(99) < pct);
      if (m_valid && m_ready) begin
        q_out.push_back(m_data);
        q_last.push_back(m_last);
        if (m_last) done = 1;
      end
    end
    if (!done) begin
      n_checks++;
      $display("FAIL consume_timeout got %0d blocks, no m_last",
               q_out.size());
    end
    @(negedge clk);
  endtask

  task automatic run_session(input bit md, input logic [63:0] ivv,
                             input int pct);
    start_pulse(md, ivv);
    fork
      feed(q_in.size(), 1'b1);
      consume(pct);
    join
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({s_ready, m_valid, m_last, sess_busy, sess_done} !== 5'b0)
      $display("FAIL reset_flags got %b exp 00000",
               {s_ready, m_valid, m_last, sess_busy, sess_done});
    else n_pass++;
    n_checks++;
    if (m_data !== 64'h0)
      $display("FAIL reset_m_data got %h exp 0", m_data);
    else n_pass++;
    n_checks++;
    if (blk_count !== 32'h0)
      $display("FAIL reset_blk_count got %0d exp 0", blk_count);
    else n_pass++;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_encrypt(output logic [63:0] ct[3]);
    int d0;
    logic [7:0] lv;
    q_in = '{64'h1111111111111111, 64'h2222222222222222,
             64'h3333333333333333};
    model(1'b0, 64'h0123456789abcdef);
    d0 = done_cnt;
    run_session(1'b0, 64'h0123456789abcdef, 100);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= q_out.size() || q_out[i] !== q_exp[i])
        $display("FAIL enc_blk%0d got %h exp %h", i,
                 (i < q_out.size()) ? q_out[i] : 64'hx, q_exp[i]);
      else n_pass++;
      ct[i] = q_exp[i];
    end
    lv = '0;
    foreach (q_last[i]) if (i < 8) lv[i] = q_last[i];
    n_checks++;
    if (lv !== 8'b0000_0100)
      $display("FAIL enc_m_last got %b exp 00000100", lv);
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 !== 1)
      $display("FAIL enc_sess_done got %0d pulses exp 1",
               done_cnt - d0);
    else n_pass++;
    n_checks++;
    if (blk_count !== 32'd3 || sess_busy !== 1'b0)
      $display("FAIL enc_count got %0d busy %b exp 3 busy 0",
               blk_count, sess_busy);
    else n_pass++;
  endtask

  task automatic test_roundtrip(input logic [63:0] ct[3]);
    logic [63:0] pt[3];
    pt = '{64'h1111111111111111, 64'h2222222222222222,
           64'h3333333333333333};
    q_in = '{ct[0], ct[1], ct[2]};
    run_session(1'b1, 64'h0123456789abcdef, 60);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= q_out.size() || q_out[i] !== pt[i])
        $display("FAIL dec_blk%0d got %h exp %h", i,
                 (i < q_out.size()) ? q_out[i] : 64'hx, pt[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_pressure();
    logic [63:0] ivv;
    int a0;
    ivv = {$urandom, $urandom};
    q_in.delete();
    repeat (4) q_in.push_back({$urandom, $urandom});
    model(1'b0, ivv);
    m_ready = 1'b0;
    a0 = acc_cnt;
    start_pulse(1'b0, ivv);
    fork
      feed(4, 1'b1);
      begin
        m_ready = 1'b0;
        repeat (200) @(negedge clk);
        n_checks++;
        if (acc_cnt - a0 !== 2)
          $display("FAIL bp_accepted got %0d exp 2", acc_cnt - a0);
        else n_pass++;
        n_checks++;
        if (s_ready !== 1'b0)
          $display("FAIL bp_s_ready got %b exp 0", s_ready);
        else n_pass++;
        n_checks++;
        if (m_valid !== 1'b1)
          $display("FAIL bp_m_valid got %b exp 1", m_valid);
        else n_pass++;
        consume(100);
      end
    join
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= q_out.size() || q_out[i] !== q_exp[i])
        $display("FAIL bp_blk%0d got %h exp %h", i,
                 (i < q_out.size()) ? q_out[i] : 64'hx, q_exp[i]);
      else n_pass++;
    end
    n_checks++;
    if (q_out.size() !== 4 || blk_count !== 32'd4)
      $display("FAIL bp_total got %0d blocks count %0d exp 4",
               q_out.size(), blk_count);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [63:0] ivv;
    int d0;
    ivv = {$urandom, $urandom};
    q_in.delete();
    repeat (3) q_in.push_back({$urandom, $urandom});
    m_ready = 1'b0;
    start_pulse(1'b0, ivv);
    feed(2, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (m_valid !== 1'b1 || sess_busy !== 1'b1)
      $display("FAIL abort_pre got valid %b busy %b exp 1 1",
               m_valid, sess_busy);
    else n_pass++;
    d0 = done_cnt;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if ({sess_busy, m_valid, s_ready} !== 3'b000)
      $display("FAIL abort_idle got busy/valid/ready %b exp 000",
               {sess_busy, m_valid, s_ready});
    else n_pass++;
    repeat (40) @(negedge clk);
    n_checks++;
    if (done_cnt !== d0 || m_valid !== 1'b0)
      $display("FAIL abort_no_done got %0d pulses valid %b exp 0 0",
               done_cnt - d0, m_valid);
    else n_pass++;
    ivv = {$urandom, $urandom};
    q_in = '{{$urandom, $urandom}};
    model(1'b0, ivv);
    run_session(1'b0, ivv, 100);
    n_checks++;
    if (q_out.size() !== 1 || q_out[0] !== q_exp[0])
      $display("FAIL abort_next got %h exp %h",
               (q_out.size() > 0) ? q_out[0] : 64'hx, q_exp[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] ivv;
    ivv = {$urandom, $urandom};
    q_in.delete();
    repeat (2) q_in.push_back({$urandom, $urandom});
    m_ready = 1'b0;
    start_pulse(1'b0, ivv);
    feed(2, 1'b1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (m_valid !== 1'b1 || sess_busy !== 1'b1 || m_data === 64'h0)
      $display("FAIL rst_pre got valid %b busy %b data %h",
               m_valid, sess_busy, m_data);
    else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({s_ready, m_valid, m_last, sess_busy, sess_done} !== 5'b0
        || m_data !== 64'h0 || blk_count !== 32'h0)
      $display("FAIL rst_async got flags %b data %h count %0d exp 0",
               {s_ready, m_valid, m_last, sess_busy, sess_done},
               m_data, blk_count);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    ivv = {$urandom, $urandom};
    q_in.delete();
    repeat (2) q_in.push_back({$urandom, $urandom});
    model(1'b1, ivv);
    run_session(1'b1, ivv, 70);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (i >= q_out.size() || q_out[i] !== q_exp[i])
        $display("FAIL rst_after_blk%0d got %h exp %h", i,
                 (i < q_out.size()) ? q_out[i] : 64'hx, q_exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_ignored();
    logic [63:0] ivv;
    int a0;
    a0 = acc_cnt;
    @(negedge clk);
    s_valid = 1'b1;
    s_data = {$urandom, $urandom};
    repeat (10) @(negedge clk);
    n_checks++;
    if (acc_cnt !== a0 || s_ready !== 1'b0)
      $display("FAIL idle_s_valid got %0d accepts ready %b exp 0 0",
               acc_cnt - a0, s_ready);
    else n_pass++;
    s_valid = 1'b0;
    ivv = {$urandom, $urandom};
    q_in.delete();
    repeat (2) q_in.push_back({$urandom, $urandom});
    model(1'b0, ivv);
    fork
      run_session(1'b0, ivv, 80);
      begin
        repeat (6) @(negedge clk);
        start = 1'b1;
        mode = 1'b1;
        iv = ~ivv;
        @(negedge clk);
        start = 1'b0;
      end
    join
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (i >= q_out.size() || q_out[i] !== q_exp[i])
        $display("FAIL busy_start_blk%0d got %h exp %h", i,
                 (i < q_out.size()) ? q_out[i] : 64'hx, q_exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [63:0] ivv;
    ivv = {$urandom, $urandom};
    q_in.delete();
    repeat (5) q_in.push_back({$urandom, $urandom});
    model(1'b0, ivv);
    run_session(1'b0, ivv, 50);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= q_out.size() || q_out[i] !== q_exp[i])
        $display("FAIL wrap_blk%0d got %h exp %h", i,
                 (i < q_out.size()) ? q_out[i] : 64'hx, q_exp[i]);
      else n_pass++;
    end
    n_checks++;
    if (blk_count !== 32'd5)
      $display("FAIL wrap_count32 got %0d exp 5", blk_count);
    else n_pass++;
    n_checks++;
    if (blk_count2 !== 2'd1)
      $display("FAIL wrap_count2 got %0d exp 1", blk_count2);
    else n_pass++;
  endtask

  initial begin
    logic [63:0] ct[3];
    key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    for (int i = 0; i < 8; i++) kw[i] = key[32*i +: 32];
    for (int j = 0; j < 8; j++)
      for (int v = 0; v < 16; v++)
        sbox[(j*16 + v)*4 +: 4] = 4'(sbt[j][v]);
    test_reset();
    test_encrypt(ct);
    test_roundtrip(ct);
    test_back_pressure();
    test_abort();
    test_reset_mid();
    test_ignored();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
